spi_servo_frontend: RTL and testbench

//  SPI slave front end for the servo register map. Deserialises one SPI frame
//  of {addr, data}, checks its length, then issues a single-cycle write strobe
//  (cs, addr, data) to the servo controller that sits directly downstream.

---
 rtl/servo_spi_pkg.sv | 22 ++
 rtl/spi_servo_frontend_if.sv | 36 +++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_servo_frontend.sv | 156 +++++++++++++++
 tb/tb_spi_servo_frontend.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/servo_spi_pkg.sv
// Shared definitions for the SPI servo front end.
//   - Default field widths and synchroniser depth.
//   - Frame width and bit-counter width derived from those defaults.
//   - FSM state encoding. The state is also exported on the debug bus.
package servo_spi_pkg;

    localparam int DEF_SIGNAL_BIT_WIDTH  = 16;
    localparam int DEF_ADDRESS_BIT_WIDTH = 2;
    localparam int DEF_SYNC_STAGES       = 2;

    localparam int FRAME_W = DEF_ADDRESS_BIT_WIDTH + DEF_SIGNAL_BIT_WIDTH;
    // Counts 0..FRAME_W+1. FRAME_W+1 is the saturated "too long" value.
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        COMMIT    = 2'd3
    } state_t;

endpackage

// File: rtl/spi_servo_frontend_if.sv
// Bus bundle between an SPI host and the SPI servo front end.
//   SPI pins : sclk, mosi, ss_n (host -> front end), miso, miso_oe (front end -> host)
//   Servo bus: cs, addr, data, frame_err (front end -> servo controller)
//   Debug    : dbg_state, the current FSM state
// Handshake: cs is a one-clk write strobe with no back-pressure. addr and data
// are valid in the cs cycle and hold until the next commit. frame_err is a
// one-clk pulse, and it is never high in the same cycle as cs.
interface spi_servo_frontend_if
    import servo_spi_pkg::*;
#(
    parameter int SIGNAL_BIT_WIDTH  = DEF_SIGNAL_BIT_WIDTH,
    parameter int ADDRESS_BIT_WIDTH = DEF_ADDRESS_BIT_WIDTH
);
    logic                         sclk;
    logic                         mosi;
    logic                         ss_n;
    logic                         miso;
    logic                         miso_oe;
    logic                         cs;
    logic [ADDRESS_BIT_WIDTH-1:0] addr;
    logic [SIGNAL_BIT_WIDTH-1:0]  data;
    logic                         frame_err;
    state_t                       dbg_state;

    // The front end itself
    modport slave (
        input  sclk, mosi, ss_n,
        output miso, miso_oe, cs, addr, data, frame_err, dbg_state
    );

    // SPI host / environment side
    modport master (
        output sclk, mosi, ss_n,
        input  miso, miso_oe, cs, addr, data, frame_err, dbg_state
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus edge detection.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   d_i     in  asynchronous input
//   level_o out synchronised level
//   rise_o  out one-clk pulse on a synchronised 0->1
//   fall_o  out one-clk pulse on a synchronised 1->0
// Everything resets to 0. For ss_n this means a frame that is already in
// progress when reset releases produces no falling edge.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_servo_frontend.sv
// SPI mode-0 slave (MSB first) that receives one {addr, data} frame per
// ss_n window. A frame with exactly FRAME_W bits produces a one-clk cs write
// strobe. Any other bit count produces a one-clk frame_err pulse. MISO shifts
// out the last accepted frame.
// Ports:
//   clk  in   system clock, the only clock in the block
//   rst  in   asynchronous active-low reset
//   bus  slave modport of spi_servo_frontend_if
//        (SPI pins, servo write bus, debug state)
module spi_servo_frontend
    import servo_spi_pkg::*;
#(
    parameter int SIGNAL_BIT_WIDTH  = DEF_SIGNAL_BIT_WIDTH,
    parameter int ADDRESS_BIT_WIDTH = DEF_ADDRESS_BIT_WIDTH,
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_servo_frontend_if.slave   bus
);
    localparam int FW = ADDRESS_BIT_WIDTH + SIGNAL_BIT_WIDTH;
    localparam int CW = $clog2(FW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    // ---------------- synchronisers ----------------
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic ss_n_s, ss_rise, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(bus.sclk),
        .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(bus.mosi),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss_n (
        .clk(clk), .rst(rst), .d_i(bus.ss_n),
        .level_o(ss_n_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    // ---------------- FSM: state register ----------------
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WAIT_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_IDLE: if (ss_n_s)  state_d = IDLE;
            IDLE:      if (ss_fall) state_d = SHIFT;
            SHIFT:     if (ss_rise) state_d = COMMIT;
            COMMIT:                 state_d = IDLE;
            default:                state_d = WAIT_IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath next state ----------------
    logic [CW-1:0]                bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]                rx_q, rx_d;
    logic [FW-1:0]                tx_q, tx_d;
    logic [FW-1:0]                readback_q, readback_d;
    logic                         miso_q, miso_d;
    logic                         cs_q, cs_d;
    logic                         ferr_q, ferr_d;
    logic [ADDRESS_BIT_WIDTH-1:0] addr_q, addr_d;
    logic [SIGNAL_BIT_WIDTH-1:0]  data_q, data_d;
    logic                         miso_oe_c;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        readback_d = readback_q;
        miso_d     = miso_q;
        cs_d       = 1'b0;
        ferr_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        miso_oe_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    bit_cnt_d = '0;
                    tx_d      = readback_q;
                    miso_d    = readback_q[FW-1];
                end
            end
            SHIFT: begin
                miso_oe_c = 1'b1;
                // An sclk edge coinciding with the ss_n rise is dropped, so
                // the bit count is frozen at the moment the frame closes.
                if (!ss_rise) begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[FW-2:0], mosi_s};
                        if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (sclk_fall) begin
                        tx_d   = {tx_q[FW-2:0], 1'b0};
                        miso_d = tx_q[FW-2];
                    end
                end
            end
            COMMIT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    cs_d       = 1'b1;
                    addr_d     = rx_q[FW-1:SIGNAL_BIT_WIDTH];
                    data_d     = rx_q[SIGNAL_BIT_WIDTH-1:0];
                    readback_d = rx_q;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            readback_q <= '0;
            miso_q     <= 1'b0;
            cs_q       <= 1'b0;
            ferr_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            readback_q <= readback_d;
            miso_q     <= miso_d;
            cs_q       <= cs_d;
            ferr_q     <= ferr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = miso_oe_c;
    assign bus.cs        = cs_q;
    assign bus.addr      = addr_q;
    assign bus.data      = data_q;
    assign bus.frame_err = ferr_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi_servo_frontend.sv
// Directed bench for spi_servo_frontend. The SPI host runs at f_clk/8, with
// 4 clk per sclk half period. Inputs are driven on the falling clk edge, and
// outputs are sampled on the falling clk edge.
module tb_spi_servo_frontend;
    import servo_spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_servo_frontend_if bus();

    spi_servo_frontend dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- output monitor (logs only) ----------------
    int                             cs_cnt     = 0;
    int                             ferr_cnt   = 0;
    int                             both_cnt   = 0;
    int                             wide_cnt   = 0;
    int                             last_cs_cyc = 0;
    logic                           prev_cs    = 1'b0;
    logic                           prev_ferr  = 1'b0;
    logic [DEF_ADDRESS_BIT_WIDTH-1:0] addr_log[$];
    logic [DEF_SIGNAL_BIT_WIDTH-1:0]  data_log[$];

    always @(negedge clk) begin
        if (rst) begin
            if (bus.cs) begin
                cs_cnt++;
                last_cs_cyc = cyc;
                addr_log.push_back(bus.addr);
                data_log.push_back(bus.data);
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.cs && bus.frame_err) both_cnt++;
            if ((bus.cs && prev_cs) || (bus.frame_err && prev_ferr)) wide_cnt++;
            prev_cs   = bus.cs;
            prev_ferr = bus.frame_err;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift bits[hi] down to bits[lo]. MISO is captured at each sclk rise.
    task automatic send_bits(input logic [31:0] bits, input int hi, input int lo,
                             inout logic [31:0] rx, inout logic oe_ok);
        for (int i = hi; i >= lo; i--) begin
            bus.mosi = bits[i];
            tick(4);
            bus.sclk = 1'b1;
            rx = {rx[30:0], bus.miso};
            if (bus.miso_oe !== 1'b1) oe_ok = 1'b0;
            tick(4);
            bus.sclk = 1'b0;
        end
    endtask

    int rise_cyc = 0;

    task automatic frame(input logic [31:0] bits, input int n,
                         output logic [31:0] rx, output logic oe_ok);
        rx    = '0;
        oe_ok = 1'b1;
        bus.ss_n = 1'b0;
        tick(4);
        send_bits(bits, n - 1, 0, rx, oe_ok);
        tick(4);
        bus.ss_n = 1'b1;
        rise_cyc = cyc;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rx, rx2;
    logic        oe, oe2;

    initial begin
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.ss_n = 1'b1;
        rst      = 1'b0;
        tick(3);

        // Reset state
        check("rst_cs",      32'(bus.cs),        32'h0);
        check("rst_ferr",    32'(bus.frame_err), 32'h0);
        check("rst_miso",    32'(bus.miso),      32'h0);
        check("rst_miso_oe", 32'(bus.miso_oe),   32'h0);
        check("rst_addr",    32'(bus.addr),      32'h0);
        check("rst_data",    32'(bus.data),      32'h0);
        check("rst_state",   32'(bus.dbg_state), 32'(WAIT_IDLE));
        rst = 1'b1;
        tick(5);
        check("idle_after_rst", 32'(bus.dbg_state), 32'(IDLE));

        // 1: addr=2, data=0x05DC
        frame(32'h0002_05DC, 18, rx, oe);
        tick(8);
        check("t1_cs_cnt",   32'(cs_cnt),   32'd1);
        check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("t1_addr",     32'(bus.addr), 32'h2);
        check("t1_data",     32'(bus.data), 32'h05DC);
        check("t1_latency",  32'(last_cs_cyc - rise_cyc), 32'd4);
        check("t1_miso",     rx,            32'h0);
        check("t1_miso_oe",  32'(oe),       32'h1);
        check("t1_oe_off",   32'(bus.miso_oe), 32'h0);

        // 2: 10-bit then 20-bit frames are discarded
        frame(32'h0000_02AB, 10, rx, oe);
        tick(8);
        check("t2_ferr_short", 32'(ferr_cnt), 32'd1);
        frame(32'h000A_BCDE, 20, rx, oe);
        tick(8);
        check("t2_ferr_long", 32'(ferr_cnt), 32'd2);
        check("t2_cs_cnt",    32'(cs_cnt),   32'd1);
        check("t2_addr",      32'(bus.addr), 32'h2);
        check("t2_data",      32'(bus.data), 32'h05DC);

        // 3: readback of frame 1 while writing addr=1, data=0x1234
        frame(32'h0001_1234, 18, rx, oe);
        tick(8);
        check("t3_miso",    rx,            32'h0002_05DC);
        check("t3_cs_cnt",  32'(cs_cnt),   32'd2);
        check("t3_addr",    32'(bus.addr), 32'h1);
        check("t3_data",    32'(bus.data), 32'h1234);

        // 4: reset after bit 9, release with ss_n low, finish the frame
        rx = '0;
        oe = 1'b1;
        bus.ss_n = 1'b0;
        tick(4);
        send_bits(32'h0003_BEEF, 17, 9, rx, oe);
        check("t4_mid_state", 32'(bus.dbg_state), 32'(SHIFT));
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        send_bits(32'h0003_BEEF, 8, 0, rx, oe);
        tick(4);
        bus.ss_n = 1'b1;
        tick(8);
        check("t4_cs_cnt",   32'(cs_cnt),   32'd2);
        check("t4_ferr_cnt", 32'(ferr_cnt), 32'd2);
        check("t4_addr",     32'(bus.addr), 32'h0);
        check("t4_data",     32'(bus.data), 32'h0);
        check("t4_state",    32'(bus.dbg_state), 32'(IDLE));
        frame(32'h0003_CAFE, 18, rx, oe);
        tick(8);
        check("t4_miso_cleared", rx,          32'h0);
        check("t4_next_cs_cnt", 32'(cs_cnt),  32'd3);
        check("t4_next_addr",  32'(bus.addr), 32'h3);
        check("t4_next_data",  32'(bus.data), 32'hCAFE);

        // 5: back-to-back frames with a 4 clk ss_n gap
        frame(32'h0001_1111, 18, rx, oe);
        tick(4);
        frame(32'h0002_2222, 18, rx2, oe2);
        tick(8);
        check("t5_cs_cnt",   32'(cs_cnt),   32'd5);
        check("t5_ferr_cnt", 32'(ferr_cnt), 32'd2);
        check("t5_miso_a",   rx,            32'h0003_CAFE);
        check("t5_miso_b",   rx2,           32'h0001_1111);
        check("t5_addr_a",   32'(addr_log[3]), 32'h1);
        check("t5_data_a",   32'(data_log[3]), 32'h1111);
        check("t5_addr_b",   32'(addr_log[4]), 32'h2);
        check("t5_data_b",   32'(data_log[4]), 32'h2222);

        // Pulse shape over the whole run
        check("cs_ferr_overlap", 32'(both_cnt), 32'd0);
        check("pulse_width",     32'(wide_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
